// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register: one main entry, optional skid entry when
// PIPE_STAGE_REG_SKID_EN is defined (registered in_ready, capacity 2).
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] KILL_MASK = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             accept;
  logic             out_fire;

  assign accept   = in_valid && in_ready;
  assign out_fire = main_valid_q && out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  assign in_ready = !skid_valid_q;

  // skid_valid implies main_valid, so a full stage only ever drains skid->main
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (out_ready) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q && !out_ready) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end else begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign in_ready = !main_valid_q || out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data;
    end else if (out_fire) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q & (main_valid_q ? {WIDTH{1'b1}} : ~KILL_MASK);

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning payload width in bits (control bundle: write enables, load_src, result_src, ...).
REQ-002 SHALL have parameter KILL_MASK, WIDTH bits, default all-ones, meaning payload bits forced to 0 whenever out_valid is 0 (write enables, so bubbles never write).
REQ-003 SHALL have port clk, input, 1, single clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream beat present.
REQ-006 SHALL have port in_ready, output, 1, stage can accept a beat this cycle.
REQ-007 SHALL have port in_data, input, WIDTH, upstream payload.
REQ-008 SHALL have port flush, input, 1, synchronous kill of all held beats (branch/exception squash).
REQ-009 SHALL have port out_valid, output, 1, downstream beat present.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts; low means stall.
REQ-011 SHALL have port out_data, output, WIDTH, registered payload, masked per REQ-002.

Function
REQ-012 SHALL transfer a beat upstream when in_valid and in_ready are both 1 on a rising clk edge, and downstream when out_valid and out_ready are both 1.
REQ-013 SHALL hold one main entry (main_valid, main_data); out_valid = main_valid; out_data = main_data AND (main_valid ? all-ones : ~KILL_MASK).
REQ-014 SHALL have latency exactly 1 cycle: a beat accepted at edge N appears on out_valid/out_data after edge N when the stage was empty or draining.
REQ-015 SHALL load data registers only on an accepted beat; held data SHALL not change while out_ready is 0 (stall holds contents).
REQ-016 SHALL, on a simultaneous downstream transfer and upstream accept, replace the main entry with the new beat with no bubble (full throughput, one beat per cycle).
REQ-017 SHALL, when flush is 1 at an edge, clear every valid bit at that edge with highest priority over accept and transfer; a beat accepted in the same cycle SHALL be discarded; data registers may keep stale values but out_data killed bits read 0.
REQ-018 SHALL not drop or duplicate beats: every accepted, unflushed beat is presented exactly once, in order.
REQ-019 SHALL not change out_valid from 1 to 0 or change out_data while out_ready is 0, except by flush or reset.

Reset
REQ-020 SHALL, while reset_n is 0, asynchronously force all valid bits 0 and all data registers 0; thus out_valid=0, out_data=0, in_ready=1 (both configurations).
REQ-021 SHALL, on reset assertion mid-operation, discard all held beats; first accept possible at first rising edge after reset_n deasserts.

Configuration
REQ-022 SHALL support macro PIPE_STAGE_REG_SKID_EN selecting the ready path.
REQ-023 SHALL, without PIPE_STAGE_REG_SKID_EN, drive in_ready = !main_valid || out_ready combinationally (one entry, combinational ready path).
REQ-024 SHALL, with PIPE_STAGE_REG_SKID_EN, add one skid entry (skid_valid, skid_data) and drive in_ready = !skid_valid from a register only.
REQ-025 SHALL, with skid: beat accepted while main_valid=1 and out_ready=0 goes to skid; when out_ready=1 and skid_valid=1, skid moves to main at the transfer edge and skid frees; order preserved; capacity 2 beats.

Verification (WIDTH=8, KILL_MASK=8'h03)
REQ-026 SHALL cover reset: reset_n=0 mid-stream with main holding 8'hFF -> out_valid=0, out_data=8'h00, in_ready=1 immediately, without a clock edge.
REQ-027 SHALL cover streaming: out_ready=1, in_valid=1 with 8'h11,8'h22,8'h33 on consecutive edges -> out_data 8'h11,8'h22,8'h33 one cycle later each, out_valid stays 1, no gaps.
REQ-028 SHALL cover stall: load 8'h5A, hold out_ready=0 for 4 cycles -> out_data=8'h5A stable and out_valid=1; no-skid in_ready=0; skid accepts one more beat 8'hA5, then in_ready=0; release -> 8'h5A then 8'hA5.
REQ-029 SHALL cover flush: main holds 8'hF7, flush=1 with in_valid=1 and in_data=8'h0F -> next cycle out_valid=0, out_data bits[1:0]=0, 8'h0F never appears.
REQ-030 SHALL cover kill mask: after flush, out_data AND 8'h03 = 0 every cycle until the next accepted beat.
REQ-031 SHALL cover random in_valid/out_ready for 10000 cycles against a FIFO scoreboard -> no loss, duplication or reordering, in both macro settings.
